// File: rtl/snd_mix_dsm.sv
// Audio mixer: APU sample plus gain-scaled mapper sample, saturated, one-pole lowpass,
// then a first-order delta-sigma bitstream of the filtered mix.
module snd_mix_dsm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        smp_stb,
   input  logic [15:0] apu_snd,
   input  logic [15:0] map_snd,
   input  logic [3:0]  map_vol,
   input  logic        mute,
   output logic [15:0] pcm_out,
   output logic        pcm_vld,
   output logic        dac_out
);

   localparam int STAGES = 3;

   typedef struct packed {
      logic [16:0] g;
      logic [15:0] apu;
      logic        mute;
   } s1_t;

   logic [STAGES:0]    vld_pipe;
   s1_t                s1_q;
   logic [15:0]        m_q;
   logic [15:0]        y_q;
   logic [15:0]        acc_q;
   logic               dac_q;

   logic [19:0]        prod;
   logic [17:0]        s_sum;
   logic [15:0]        m_nxt;
   logic signed [16:0] d;
   logic signed [15:0] step;
   logic [16:0]        dsum;

   assign vld_pipe[0] = smp_stb;

   // map_vol / 8: 8 is unity, 15 is 1.875x
   assign prod  = {4'b0, map_snd} * {16'b0, map_vol};
   assign s_sum = {1'b0, s1_q.apu} + {1'b0, s1_q.g};

   always_comb begin
      m_nxt = s_sum[15:0];
      if (s_sum[17:16] != 2'b00) m_nxt = 16'hFFFF;
      if (s1_q.mute)             m_nxt = 16'h0000;
   end

   // Arithmetic shift floors toward -inf, so falls land exactly and rises stop up to 7 short
   assign d    = $signed({1'b0, m_q}) - $signed({1'b0, y_q});
   assign step = 16'(d >>> 3);
   assign dsum = {1'b0, acc_q} + {1'b0, y_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[STAGES:1] <= '0;
         s1_q               <= '0;
         m_q                <= '0;
         y_q                <= '0;
         acc_q              <= '0;
         dac_q              <= 1'b0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (vld_pipe[0]) begin
            s1_q.g    <= 17'(prod >> 3);
            s1_q.apu  <= apu_snd;
            s1_q.mute <= mute;
         end
         if (vld_pipe[1]) m_q <= m_nxt;
         if (vld_pipe[2]) y_q <= y_q + step;
         acc_q <= dsum[15:0];
         dac_q <= dsum[16];
      end
   end

   assign pcm_out = y_q;
   assign pcm_vld = vld_pipe[STAGES];
   assign dac_out = dac_q;

endmodule

// File: tb/tb_snd_mix_dsm.sv
// Directed bench for snd_mix_dsm: vector table, settling sequences, back-to-back,
// delta-sigma density and mid-flight reset.
module tb_snd_mix_dsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        smp_stb = 1'b0;
   logic [15:0] apu_snd = '0;
   logic [15:0] map_snd = '0;
   logic [3:0]  map_vol = '0;
   logic        mute = 1'b0;
   logic [15:0] pcm_out;
   logic        pcm_vld;
   logic        dac_out;

   int total = 0;
   int bad   = 0;

   snd_mix_dsm dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .smp_stb (smp_stb),
      .apu_snd (apu_snd),
      .map_snd (map_snd),
      .map_vol (map_vol),
      .mute    (mute),
      .pcm_out (pcm_out),
      .pcm_vld (pcm_vld),
      .dac_out (dac_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] apu;
      logic [15:0] map;
      logic [3:0]  vol;
      logic        mu;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[8];
   vec_t b2b[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   // Called away from posedge; returns on the negedge where pcm_vld was seen.
   // Inputs are scrambled after the strobe to show they are ignored without smp_stb.
   task automatic strobe(input logic [15:0] a, input logic [15:0] m,
                         input logic [3:0] v, input logic mu);
      int lat = 0;
      apu_snd = a; map_snd = m; map_vol = v; mute = mu; smp_stb = 1'b1;
      @(posedge clk); #1;
      smp_stb = 1'b0;
      apu_snd = 16'($urandom); map_snd = 16'($urandom);
      map_vol = 4'($urandom);  mute = 1'($urandom);
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(negedge clk);
         if (pcm_vld) lat = i;
      end
      chk("latency", lat, 3);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      logic mono;
      logic [15:0] prev;
      logic [15:0] got[$];
      int cyc[$];

      tbl[0] = '{16'h0000, 16'h8000, 4'd8,  1'b0, 16'h1000};
      tbl[1] = '{16'h0000, 16'h8000, 4'd8,  1'b0, 16'h1E00};
      tbl[2] = '{16'h2000, 16'hFFFF, 4'd0,  1'b0, 16'h1E40};
      tbl[3] = '{16'h1234, 16'h5678, 4'd8,  1'b1, 16'h1A78};
      tbl[4] = '{16'hC000, 16'hC000, 4'd15, 1'b0, 16'h3728};
      tbl[5] = '{16'h0000, 16'h1000, 4'd15, 1'b0, 16'h3403};
      tbl[6] = '{16'h3403, 16'h0007, 4'd1,  1'b0, 16'h3403};
      tbl[7] = '{16'h0010, 16'h0008, 4'd9,  1'b0, 16'h2D85};

      b2b[0] = '{16'h0800, 16'h0000, 4'd0,  1'b0, 16'h0100};
      b2b[1] = '{16'h1000, 16'h0100, 4'd8,  1'b0, 16'h0300};
      b2b[2] = '{16'h4000, 16'h4000, 4'd8,  1'b1, 16'h02A0};
      b2b[3] = '{16'hFFFF, 16'hFFFF, 4'd15, 1'b0, 16'h224B};
      b2b[4] = '{16'h0000, 16'h0010, 4'd4,  1'b0, 16'h1E02};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pcm", pcm_out, 16'h0000);
      chk("rst_vld", pcm_vld, 1'b0);
      chk("rst_dac", dac_out, 1'b0);
      rst_n = 1'b1;

      // pcm_out = 0 gives no ones
      ones = 0;
      repeat (2048) begin @(negedge clk); ones += int'(dac_out); end
      chk("dsm_zero", ones, 0);

      // Vector table, filter state carried from one entry to the next
      for (int i = 0; i < 8; i++) begin
         strobe(tbl[i].apu, tbl[i].map, tbl[i].vol, tbl[i].mu);
         chk($sformatf("vec%0d", i), pcm_out, tbl[i].exp);
         @(negedge clk);
         chk($sformatf("vec%0d_vld_off", i), pcm_vld, 1'b0);
         @(negedge clk);
         chk($sformatf("vec%0d_hold", i), pcm_out, tbl[i].exp);
      end

      // Rising settle toward 0x8000 stops 7 short
      do_reset();
      repeat (80) strobe(16'h0000, 16'h8000, 4'd8, 1'b0);
      chk_rng("settle_rng", int'(pcm_out), 'h7FF9, 'h8000);
      chk("settle_8000", pcm_out, 16'h7FF9);

      // Saturated stage-2 input: monotonic rise, no wrap
      mono = 1'b1;
      prev = pcm_out;
      repeat (100) begin
         strobe(16'hC000, 16'hC000, 4'd15, 1'b0);
         if (pcm_out < prev) mono = 1'b0;
         prev = pcm_out;
      end
      chk("rise_mono", mono, 1'b1);
      chk("rise_final", pcm_out, 16'hFFF8);

      // Falling settle is exact, then mute decays to exactly 0
      repeat (120) strobe(16'h8000, 16'h0000, 4'd0, 1'b0);
      chk("fall_8000", pcm_out, 16'h8000);
      strobe(16'h1234, 16'h5678, 4'd8, 1'b1);
      chk("mute_step", pcm_out, 16'h7000);
      repeat (120) strobe(16'h1234, 16'h5678, 4'd8, 1'b1);
      chk("mute_zero", pcm_out, 16'h0000);

      // Back-to-back strobes
      do_reset();
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               apu_snd = b2b[k].apu; map_snd = b2b[k].map;
               map_vol = b2b[k].vol; mute = b2b[k].mu; smp_stb = 1'b1;
               @(posedge clk); #1;
            end
            smp_stb = 1'b0;
         end
         begin
            for (int c = 0; c < 12; c++) begin
               @(negedge clk);
               if (pcm_vld) begin got.push_back(pcm_out); cyc.push_back(c); end
            end
         end
      join
      chk("b2b_count", got.size(), 5);
      if (cyc.size() > 0) chk("b2b_first_lat", cyc[0], 2);
      for (int k = 0; k < 5; k++) begin
         if (k < got.size()) begin
            chk($sformatf("b2b%0d", k), got[k], b2b[k].exp);
            chk($sformatf("b2b%0d_cyc", k), cyc[k], cyc[0] + k);
         end
      end

      // Constant pcm_out = 0x4000 density
      do_reset();
      strobe(16'hFFFF, 16'h0000, 4'd0, 1'b0);
      chk("dsm_set0", pcm_out, 16'h1FFF);
      strobe(16'hFFFF, 16'h0000, 4'd0, 1'b0);
      chk("dsm_set1", pcm_out, 16'h3BFF);
      strobe(16'h5C07, 16'h0000, 4'd0, 1'b0);
      chk("dsm_set2", pcm_out, 16'h4000);
      repeat (2) @(negedge clk);
      ones = 0;
      repeat (65536) begin @(negedge clk); ones += int'(dac_out); end
      chk_rng("dsm_4000", ones, 16383, 16385);

      // Reset one cycle after a strobe: sample discarded, outputs cleared at once
      apu_snd = 16'hFFFF; map_snd = 16'h0000; map_vol = 4'd0; mute = 1'b0; smp_stb = 1'b1;
      @(posedge clk); #1;
      smp_stb = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_pcm", pcm_out, 16'h0000);
      chk("async_dac", dac_out, 1'b0);
      chk("async_vld", pcm_vld, 1'b0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      strobe(16'h0800, 16'h0000, 4'd0, 1'b0);
      chk("post_rst", pcm_out, 16'h0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
